// File: rtl/spi_regfile_periph_if.sv
// spi_regfile_periph_if: SPI pins plus register-bank buses of the register-file peripheral
interface spi_regfile_periph_if #(
  parameter int DATA_W = 8,
  parameter int N_WR   = 3,
  parameter int N_RD   = 56
);
  logic                   csn;
  logic                   pico;
  logic                   poci;
  logic [N_RD*DATA_W-1:0] rd_regs_i;
  logic [N_WR*DATA_W-1:0] wr_regs_o;
  logic [N_WR-1:0]        wr_toggle_o;
  modport master (output csn, pico, rd_regs_i, input poci, wr_regs_o, wr_toggle_o);
  modport slave  (input csn, pico, rd_regs_i, output poci, wr_regs_o, wr_toggle_o);
endinterface

// File: rtl/spi_regfile_periph.sv
// spi_regfile_periph: SPI mode-0 register file (writable bank + read-only bank, auto-increment); SPI_RF_WR_ECHO_EN echoes pre-write data on poci
module spi_regfile_periph #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int N_WR   = 3,
  parameter int N_RD   = 56
) (
  input  logic                 sclk,
  input  logic                 rstn,
  spi_regfile_periph_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W);
  typedef enum logic {CMD, DATA} phase_t;
  phase_t                 r_phase, w_phase_nxt;
  logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic                   r_rw, w_rw_nxt;
  logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
  logic [DATA_W-2:0]      r_rx;
  logic [DATA_W-1:0]      r_tx;
  logic [N_WR*DATA_W-1:0] r_wr_regs;
  logic [N_WR-1:0]        r_tog;
  logic                   r_armed;
  logic [DATA_W-1:0]      w_rx_byte, w_rd_val, w_tx_load;
  logic                   w_byte_done, w_wr_en, w_frame_rstn;
  assign w_rx_byte    = {r_rx, bus.pico};
  assign w_byte_done  = r_bit_cnt == CNT_W'(DATA_W-1);
  assign w_wr_en      = r_phase == DATA && r_rw && w_byte_done;
  assign w_frame_rstn = rstn && !bus.csn && r_armed;
  assign bus.poci        = r_tx[DATA_W-1];
  assign bus.wr_regs_o   = r_wr_regs;
  assign bus.wr_toggle_o = r_tog;
`ifdef SPI_RF_WR_ECHO_EN
  assign w_tx_load = w_rd_val;
`else
  assign w_tx_load = r_rw ? '0 : w_rd_val;
`endif
  // Arm framing on a csn fall so a frame interrupted by rstn stays dead until csn is re-asserted
  always_ff @(negedge bus.csn or negedge rstn)
    if (!rstn) r_armed <= 1'b0;
    else       r_armed <= 1'b1;
  // Next-state for the command/data framing FSM and address pointer
  always_comb begin
    w_bit_cnt_nxt = w_byte_done ? '0 : r_bit_cnt + CNT_W'(1);
    w_phase_nxt   = w_byte_done ? DATA : r_phase;
    w_rw_nxt      = (r_phase == CMD && w_byte_done) ? w_rx_byte[DATA_W-1] : r_rw;
    w_addr_nxt    = !w_byte_done ? r_addr : r_phase == CMD ? w_rx_byte[ADDR_W-1:0] : r_addr + ADDR_W'(1);
  end
  // Frame state on rising sclk, cleared while csn is high or reset is asserted
  always_ff @(posedge sclk or negedge w_frame_rstn)
    if (!w_frame_rstn) begin
      r_phase   <= CMD;
      r_bit_cnt <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_rx      <= '0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_rw      <= w_rw_nxt;
      r_addr    <= w_addr_nxt;
      r_rx      <= w_rx_byte[DATA_W-2:0];
    end
  // Read mux: writable bank, then read-only bank, everything else reads zero
  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < N_WR; k++)
      if (r_addr == ADDR_W'(k+1)) w_rd_val = r_wr_regs[k*DATA_W +: DATA_W];
    for (int k = 0; k < N_RD; k++)
      if (r_addr == ADDR_W'(N_WR+1+k)) w_rd_val = bus.rd_regs_i[k*DATA_W +: DATA_W];
  end
  // Writable registers and update toggles; only rstn clears them
  always_ff @(posedge sclk or negedge rstn)
    if (!rstn) begin
      r_wr_regs <= '0;
      r_tog     <= '0;
    end else begin
      for (int k = 0; k < N_WR; k++)
        if (w_wr_en && r_addr == ADDR_W'(k+1)) begin
          r_wr_regs[k*DATA_W +: DATA_W] <= w_rx_byte;
          r_tog[k]                      <= ~r_tog[k];
        end
    end
  // Transmit shifter: load at the falling edge following each completed byte, else shift out MSB first
  always_ff @(negedge sclk or negedge w_frame_rstn)
    if (!w_frame_rstn) r_tx <= '0;
    else r_tx <= (r_phase == DATA && r_bit_cnt == '0) ? w_tx_load : {r_tx[DATA_W-2:0], 1'b0};
endmodule

// File: tb/tb_spi_regfile_periph.sv
// tb_spi_regfile_periph: directed SPI frames against hand-computed register contents
module tb_spi_regfile_periph;
  logic sclk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] rx;
  spi_regfile_periph_if #(.DATA_W(8), .N_WR(3), .N_RD(56)) intf ();
  spi_regfile_periph #(.DATA_W(8), .ADDR_W(7), .N_WR(3), .N_RD(56)) u_dut (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (intf.slave)
  );
  always #5 sclk = ~sclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic frame_start();
    @(negedge sclk);
    #1 intf.csn = 1'b0;
  endtask
  task automatic frame_stop();
    intf.csn = 1'b1;
    repeat (2) @(negedge sclk);
    #1;
  endtask
  task automatic xbyte(input logic [7:0] tx, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      intf.pico = tx[i];
      @(posedge sclk);
      #1 r[i] = intf.poci;
      @(negedge sclk);
      #1;
    end
  endtask
  initial begin
    intf.csn  = 1'b1;
    intf.pico = 1'b0;
    for (int k = 0; k < 56; k++) intf.rd_regs_i[k*8 +: 8] = 8'(k + 8'h40);
    intf.rd_regs_i[0 +: 8]     = 8'hC3;
    intf.rd_regs_i[55*8 +: 8]  = 8'h5A;
    #20;
    check("rst_wr",   32'(intf.wr_regs_o),   32'h0);
    check("rst_tog",  32'(intf.wr_toggle_o), 32'h0);
    check("rst_poci", 32'(intf.poci),        32'h0);
    rstn = 1'b1;
    // single write to addr 2
    frame_start();
    xbyte(8'h82, 8, rx);
    check("wr1_cmd_poci", 32'(rx), 32'h0);
    xbyte(8'hA5, 8, rx);
    check("wr1_data_poci", 32'(rx), 32'h0);
    check("wr1_regs_in_frame", 32'(intf.wr_regs_o), 32'h00A500);
    frame_stop();
    check("wr1_regs", 32'(intf.wr_regs_o),   32'h00A500);
    check("wr1_tog",  32'(intf.wr_toggle_o), 32'h2);
    check("idle_poci", 32'(intf.poci), 32'h0);
    // reset clears the bank
    rstn = 1'b0;
    #7;
    check("rst2_wr",  32'(intf.wr_regs_o),   32'h0);
    check("rst2_tog", 32'(intf.wr_toggle_o), 32'h0);
    rstn = 1'b1;
    // burst write with overrun into the read-only bank
    frame_start();
    xbyte(8'h81, 8, rx);
    xbyte(8'h11, 8, rx);
    xbyte(8'h22, 8, rx);
    xbyte(8'h33, 8, rx);
    xbyte(8'h44, 8, rx);
`ifdef SPI_RF_WR_ECHO_EN
    check("burst_echo_addr4", 32'(rx), 32'hC3);
`else
    check("burst_echo_addr4", 32'(rx), 32'h00);
`endif
    frame_stop();
    check("burst_regs", 32'(intf.wr_regs_o),   32'h332211);
    check("burst_tog",  32'(intf.wr_toggle_o), 32'h7);
    // burst read across writable/read-only boundary
    frame_start();
    xbyte(8'h03, 8, rx);
    check("rd3_cmd_poci", 32'(rx), 32'h0);
    xbyte(8'h00, 8, rx);
    check("rd_addr3", 32'(rx), 32'h33);
    xbyte(8'h00, 8, rx);
    check("rd_addr4", 32'(rx), 32'hC3);
    frame_stop();
    // read-only end into unmapped space
    frame_start();
    xbyte(8'h3B, 8, rx);
    xbyte(8'hFF, 8, rx);
    check("rd_addr59", 32'(rx), 32'h5A);
    xbyte(8'hFF, 8, rx);
    check("rd_addr60", 32'(rx), 32'h00);
    frame_stop();
    // address wrap 127 -> 0 -> 1
    frame_start();
    xbyte(8'h7F, 8, rx);
    xbyte(8'h00, 8, rx);
    check("rd_addr127", 32'(rx), 32'h00);
    xbyte(8'h00, 8, rx);
    check("rd_addr0", 32'(rx), 32'h00);
    xbyte(8'h00, 8, rx);
    check("rd_wrap_addr1", 32'(rx), 32'h11);
    frame_stop();
    // aborted partial byte
    frame_start();
    xbyte(8'h81, 8, rx);
    xbyte(8'hFF, 5, rx);
    frame_stop();
    check("abort_regs", 32'(intf.wr_regs_o),   32'h332211);
    check("abort_tog",  32'(intf.wr_toggle_o), 32'h7);
    frame_start();
    xbyte(8'h01, 8, rx);
    xbyte(8'h00, 8, rx);
    check("abort_rd_addr1", 32'(rx), 32'h11);
    frame_stop();
    // reset mid-read-frame, then clocks without a fresh csn fall must be ignored
    frame_start();
    xbyte(8'h01, 8, rx);
    xbyte(8'h00, 3, rx);
    check("mid_poci_before_rst", 32'(intf.poci), 32'h1);
    rstn = 1'b0;
    #1;
    check("mid_rst_poci", 32'(intf.poci),        32'h0);
    check("mid_rst_wr",   32'(intf.wr_regs_o),   32'h0);
    check("mid_rst_tog",  32'(intf.wr_toggle_o), 32'h0);
    @(negedge sclk);
    #1 rstn = 1'b1;
    xbyte(8'h82, 8, rx);
    xbyte(8'h77, 8, rx);
    check("post_rst_no_frame_wr",  32'(intf.wr_regs_o),   32'h0);
    check("post_rst_no_frame_tog", 32'(intf.wr_toggle_o), 32'h0);
    frame_stop();
    frame_start();
    xbyte(8'h83, 8, rx);
    xbyte(8'h99, 8, rx);
    frame_stop();
    check("new_frame_wr",  32'(intf.wr_regs_o),   32'h990000);
    check("new_frame_tog", 32'(intf.wr_toggle_o), 32'h4);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_regfile_periph.md
# spi_regfile_periph

Parametrised SPI mode-0 register-file peripheral for the PSEC5 digital core. It receives framed serial commands on `pico` and writes a configurable bank of writable registers. It also serialises both writable and read-only registers onto `poci`, with address auto-increment. It generalises the fixed three-writable and fifty-six-read-only register block by adding chip-select framing, an explicit read/write command bit and flop-based write storage with per-register update toggles.

## Interface
- `DATA_W`, 8, register width in bits; also the SPI byte length.
- `ADDR_W`, 7, address field width; the command word is `1 + ADDR_W` bits and must equal `DATA_W`.
- `N_WR`, 3, number of writable registers, mapped at addresses 1..N_WR.
- `N_RD`, 56, number of read-only registers, mapped at addresses N_WR+1..N_WR+N_RD.

Constraint: N_WR+N_RD must be at most 2^ADDR_W−1.

- `sclk`  in  1  SPI clock; the design uses both edges.
- `rstn`  in  1  reset, asynchronous, active-low.
- `csn`  in  1  frame select, active-low; while high it asynchronously clears all frame state.
- `pico`  in  1  serial data in, sampled on the rising edge of sclk.
- `poci`  out  1  serial data out, updated on the falling edge of sclk.
- `rd_regs_i`  in  N_RD*DATA_W  read-only register values; register k (addr N_WR+1+k) is at bits [k*DATA_W +: DATA_W].
- `wr_regs_o`  out  N_WR*DATA_W  writable register contents, packed the same way starting at addr 1.
- `wr_toggle_o`  out  N_WR  bit i inverts on every completed write to addr i+1; CDC-safe update indication.

## Operation
- Frame: csn falls, then one command byte, then zero or more data bytes, then csn rises. All bytes are MSB first.
- Command byte: bit DATA_W−1 = 1 means write, 0 means read. The low ADDR_W bits are the start address.
- Frame state: `bit_cnt` (log2 DATA_W bits), `phase` (CMD or DATA), `rw`, `addr`, `rx_shift`, `tx_shift`. It is reset by `!rstn || csn`.
- State machine:
  - CMD: after DATA_W rising edges, latch `rw` and `addr`, then go to DATA.
  - DATA: stays in DATA until csn rises. After each completed byte, `addr` = addr+1 mod 2^ADDR_W (wraps 2^ADDR_W−1 → 0).
- Write, on the rising edge that completes a data byte:
  - If 1 ≤ addr ≤ N_WR: register[addr] ← received byte and the matching wr_toggle bit inverts.
  - Otherwise (addr 0, read-only or unmapped): the byte is discarded with no side effect.
- Read: `tx_shift` loads register[addr] on the falling edge after each completed byte (command or data) and shifts left on every other falling edge. `poci` = tx_shift MSB.
  - Addr 0 and unmapped addresses read 0.
  - Writable addresses read the current `wr_regs_o` value.
- `poci` is 0 during the command byte and whenever csn is high.
- A partial byte at csn rise is discarded; no write and no toggle occur.
- `rstn` clears `wr_regs_o` and `wr_toggle_o`. csn does not clear them.

## Timing
- Reset values: `poci`=0, `wr_regs_o`=0, `wr_toggle_o`=0, all frame state cleared.
- Write latency: `wr_regs_o` and `wr_toggle_o` change on the DATA_W-th rising edge of the data byte, with no sclk edges needed afterwards.
- Read: the first data MSB is valid on `poci` after the falling edge that follows the DATA_W-th command bit. Each later bit follows one falling edge later.
- Read-only inputs are sampled at the tx load edge only and must be stable around that falling edge.
- Reset mid-frame: when rstn is asserted, all outputs return to reset values immediately. On release, no frame is in progress until csn has been high and then falls again.
- csn rising mid-frame clears frame state asynchronously; the next frame starts in CMD.

## Configuration
- `SPI_RF_WR_ECHO_EN`
  - Defined: during a write frame, `poci` shifts out the pre-write contents of each addressed register, using the same load and shift rules as a read.
  - Undefined: `poci` is held 0 for the whole write frame.

## Test plan
- Reset: assert rstn=0 → `wr_regs_o`=0, `wr_toggle_o`=0, `poci`=0.
- Single write: frame 0x82, 0xA5 (write, addr 2) → reg2=0xA5, `wr_toggle_o`=3'b010, reg1 and reg3 unchanged.
- Burst write with overrun: frame 0x81, 0x11, 0x22, 0x33, 0x44 → reg1..3 = 0x11/0x22/0x33. The byte to addr 4 (read-only) is ignored. `wr_toggle_o`=3'b111.
- Burst read across a boundary:
  - Setup: reg3=0x33, `rd_regs_i` addr4=0xC3, addr59=0x5A, addr60 unmapped.
  - Frame 0x03 followed by 2 dummy bytes → poci returns 0x33, 0xC3.
  - Frame 0x3B followed by 2 dummy bytes → returns 0x5A, 0x00.
- Address wrap: frame 0x7F followed by 2 dummy bytes → returns 0x00 (addr 127, unmapped) then 0x00 (addr 0).
- Aborted byte: frame 0x81, then 5 bits of 0xFF, then csn rises → reg1 and the toggle are unchanged. The next frame 0x01 reads the old reg1 value.
